// File: rtl/if_fetch_if.sv
// Instruction-fetch bus bundle: imem read channel plus the instruction-FIFO write side.
// The master modport is the fetch unit; the slave modport is the memory/FIFO side.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_full;
  logic        fifo_jmp;
  logic        fifo_jmp_bit1;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output fifo_wr_en,
    output fifo_wr_data,
    input  fifo_full,
    output fifo_jmp,
    output fifo_jmp_bit1
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  fifo_wr_en,
    input  fifo_wr_data,
    output fifo_full,
    input  fifo_jmp,
    input  fifo_jmp_bit1
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch front end: issues word reads, skid-buffers responses into the instruction
// FIFO, redirects on jmp. Optional performance counters under `IF_FETCH_PERF_EN.
module if_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        fetch_en,
  input  logic        jmp,
  input  logic [31:0] jmp_addr,
  if_fetch_if.master  bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_words,
  output logic [31:0] perf_stall_cyc
`endif
);

  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
  localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [CntW-1:0]   outst_q;
  logic [CntW-1:0]   drop_q;
  logic [CntW-1:0]   skid_cnt_q;
  logic [PtrW-1:0]   skid_rd_q;
  logic [PtrW-1:0]   skid_wr_q;
  logic [31:0]       skid_mem_q [MAX_OUTST];

  logic [CntW:0]     inflight;
  logic              req;
  logic              gnt_hit;
  logic              keep_rsp;
  logic              drop_rsp;
  logic              bypass;
  logic              skid_push;
  logic              skid_pop;
  logic              wr_en;
  logic [31:0]       wr_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MAX_OUTST - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Issue gating counts skid entries so the skid buffer can never overflow.
  always_comb begin
    inflight  = {1'b0, outst_q} + {1'b0, skid_cnt_q};
    req       = (state_q == StRun) && !jmp && (inflight < (CntW + 1)'(MAX_OUTST));
    gnt_hit   = req && bus.imem_gnt;
    keep_rsp  = bus.imem_rvalid && (drop_q == '0);
    drop_rsp  = bus.imem_rvalid && (drop_q != '0);
    skid_pop  = !jmp && (skid_cnt_q != '0) && !bus.fifo_full;
    bypass    = !jmp && keep_rsp && (skid_cnt_q == '0) && !bus.fifo_full;
    skid_push = !jmp && keep_rsp && !bypass;
    wr_en     = skid_pop || bypass;
    if (skid_pop) begin
      wr_data = skid_mem_q[skid_rd_q];
    end else if (bypass) begin
      wr_data = bus.imem_rdata;
    end else begin
      wr_data = '0;
    end
  end

  assign bus.imem_req      = req;
  assign bus.imem_addr     = pc_q;
  assign bus.fifo_wr_en    = wr_en;
  assign bus.fifo_wr_data  = wr_data;
  assign bus.fifo_jmp      = jmp;
  assign bus.fifo_jmp_bit1 = jmp_addr[1];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      pc_q       <= {BOOT_ADDR[31:2], 2'b00};
      outst_q    <= '0;
      drop_q     <= '0;
      skid_cnt_q <= '0;
      skid_rd_q  <= '0;
      skid_wr_q  <= '0;
    end else begin
      case (state_q)
        StIdle:  if (fetch_en) state_q <= StRun;
        StRun:   if (!fetch_en) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      outst_q <= outst_q + CntW'(gnt_hit) - CntW'(bus.imem_rvalid);

      if (jmp) begin
        pc_q       <= {jmp_addr[31:2], 2'b00};
        // Everything still outstanding after this cycle belongs to the old stream.
        drop_q     <= outst_q - CntW'(bus.imem_rvalid);
        skid_cnt_q <= '0;
        skid_rd_q  <= '0;
        skid_wr_q  <= '0;
      end else begin
        if (gnt_hit) begin
          pc_q <= pc_q + 32'd4;
        end
        if (drop_rsp) begin
          drop_q <= drop_q - CntW'(1);
        end
        skid_cnt_q <= skid_cnt_q + CntW'(skid_push) - CntW'(skid_pop);
        if (skid_push) begin
          skid_wr_q <= ptr_inc(skid_wr_q);
        end
        if (skid_pop) begin
          skid_rd_q <= ptr_inc(skid_rd_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (skid_push) begin
      skid_mem_q[skid_wr_q] <= bus.imem_rdata;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_words_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      perf_words_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (wr_en && (perf_words_q != '1)) begin
        perf_words_q <= perf_words_q + 32'd1;
      end
      if ((state_q == StRun) && !req && !jmp && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_words = perf_words_q;
  assign perf_stall_cyc   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: bus slave with in-order random latency, queue-based
// reference model of the fetch stream, checked every cycle on the falling edge.
module tb_if_fetch;
  localparam logic [31:0] Boot = 32'h0000_0100;
  localparam int          Max  = 2;

  logic        clk = 1'b0;
  logic        rstb;
  logic        fetch_en;
  logic        jmp;
  logic [31:0] jmp_addr;

  if_fetch_if bus ();

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_words;
  logic [31:0] perf_stall_cyc;
`endif

  if_fetch #(
    .BOOT_ADDR (Boot),
    .MAX_OUTST (Max)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .fetch_en (fetch_en),
    .jmp      (jmp),
    .jmp_addr (jmp_addr),
    .bus      (bus)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_words (perf_fetch_words),
    .perf_stall_cyc   (perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
  endfunction

  // Reference model: fetch stream as queues of addresses and words.
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_outq[$];
  int          m_drop;
  logic [31:0] m_skid[$];
  // Bus slave: addresses granted but not yet answered.
  logic [31:0] s_q[$];
  int          full_hold;

  task automatic model_reset();
    m_run = 1'b0;
    m_pc  = {Boot[31:2], 2'b00};
    m_outq.delete();
    m_drop = 0;
    m_skid.delete();
    s_q.delete();
    full_hold = 0;
  endtask

  task automatic drive(input int phase);
    logic rv;
    case (phase)
      0: begin
        fetch_en = 1'b1;
        jmp = 1'b0;
        bus.imem_gnt = 1'b1;
        bus.fifo_full = 1'b0;
        rv = (s_q.size() > 0);
      end
      1: begin
        fetch_en = 1'b1;
        jmp = 1'b0;
        bus.imem_gnt = 1'b1;
        if (full_hold == 0) full_hold = ($urandom_range(0, 3) == 0) ? 6 : -4;
        bus.fifo_full = (full_hold > 0);
        full_hold = (full_hold > 0) ? full_hold - 1 : full_hold + 1;
        rv = (s_q.size() > 0);
      end
      default: begin
        fetch_en = ($urandom_range(0, 11) != 0);
        jmp = ($urandom_range(0, 12) == 0);
        bus.imem_gnt = ($urandom_range(0, 2) != 0);
        bus.fifo_full = ($urandom_range(0, 3) == 0);
        rv = (s_q.size() > 0) && ($urandom_range(0, 2) != 0);
      end
    endcase
    case ($urandom_range(0, 3))
      0: jmp_addr = 32'h0000_2002;
      1: jmp_addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: jmp_addr = $urandom;
    endcase
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(s_q[0]) : $urandom;
  endtask

  task automatic cycle(input int phase);
    bit          exp_req, exp_wr, bypass, pop_skid, rv;
    logic [31:0] exp_data, rsp_word, a;
    @(posedge clk);
    #1;
    drive(phase);
    @(negedge clk);
    rv       = bus.imem_rvalid;
    rsp_word = (m_outq.size() > 0) ? mem_word(m_outq[0]) : 32'h0;
    exp_req  = m_run && !jmp && (m_outq.size() + m_skid.size() < Max);
    pop_skid = !jmp && (m_skid.size() > 0) && !bus.fifo_full;
    bypass   = !jmp && rv && (m_drop == 0) && (m_skid.size() == 0) && !bus.fifo_full;
    exp_wr   = pop_skid || bypass;
    exp_data = pop_skid ? m_skid[0] : rsp_word;

    check("imem_req", bus.imem_req, exp_req);
    check("imem_addr", bus.imem_addr, m_pc);
    check("fifo_wr_en", bus.fifo_wr_en, exp_wr);
    if (exp_wr) check("fifo_wr_data", bus.fifo_wr_data, exp_data);
    check("fifo_jmp", bus.fifo_jmp, jmp);
    check("fifo_jmp_bit1", bus.fifo_jmp_bit1, jmp_addr[1]);

    // Model update for the coming edge.
    a = 32'h0;
    if (rv && m_outq.size() > 0) a = m_outq.pop_front();
    if (jmp) begin
      m_skid.delete();
      m_drop = m_outq.size();
      m_pc   = {jmp_addr[31:2], 2'b00};
    end else begin
      if (pop_skid) void'(m_skid.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (!bypass) m_skid.push_back(mem_word(a));
      end
      if (exp_req && bus.imem_gnt) begin
        m_outq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = fetch_en;

    // Slave bookkeeping follows what the DUT actually did on the bus.
    if (bus.imem_rvalid && s_q.size() > 0) void'(s_q.pop_front());
    if (bus.imem_req && bus.imem_gnt) s_q.push_back(bus.imem_addr);
  endtask

  task automatic idle_inputs();
    fetch_en = 1'b0;
    jmp = 1'b0;
    jmp_addr = 32'h0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_req"}, bus.imem_req, 1'b0);
    check({tag, "_wr_en"}, bus.fifo_wr_en, 1'b0);
    check({tag, "_wr_data"}, bus.fifo_wr_data, 32'h0);
    check({tag, "_addr"}, bus.imem_addr, {Boot[31:2], 2'b00});
  endtask

  initial begin
    idle_inputs();
    rstb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");
    @(negedge clk);
    rstb = 1'b1;

    repeat (40) cycle(0);
    repeat (200) cycle(1);
    for (int r = 0; r < 6; r++) begin
      repeat (400) cycle(2);
      // Asynchronous reset in the middle of traffic.
      @(posedge clk);
      #2;
      idle_inputs();
      rstb = 1'b0;
      #1;
      reset_check("midreset");
      model_reset();
      @(negedge clk);
      rstb = 1'b1;
      repeat (20) cycle(r % 2);
    end
    // Walk across the top of the address space.
    @(posedge clk);
    #1;
    fetch_en = 1'b1;
    jmp = 1'b1;
    jmp_addr = 32'hFFFF_FFF4;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    check("wrap_jmp_req", bus.imem_req, 1'b0);
    if (bus.imem_rvalid && s_q.size() > 0) void'(s_q.pop_front());
    m_skid.delete();
    m_drop = m_outq.size();
    m_pc = 32'hFFFF_FFF4;
    m_run = 1'b1;
    repeat (30) cycle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
